// File: rtl/hlsm_accum_pkg.sv
// Shared types and constants for the hlsm_accum triangular-sum block.
package hlsm_accum_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StWait,
        StInit,
        StCheck,
        StAdd
    } state_e;

endpackage

// File: rtl/hlsm_accum_dp.sv
// Datapath for hlsm_accum: captured bound, loop index, running sum and the one-cycle result.
module hlsm_accum_dp
    import hlsm_accum_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             add,
    input  logic             emit,
    input  logic [WIDTH-1:0] n,
    output logic             lt,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] i_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] result_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q      <= '0;
            i_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
        end else begin
            if (load) begin
                n_q <= n;
            end
            if (clear) begin
                sum_q <= '0;
                i_q   <= '0;
            end else if (add) begin
                sum_q <= sum_q + i_q;
                i_q   <= i_q + 1'b1;
            end
            // Result is nonzero only in the cycle after the loop exits.
            result_q <= emit ? sum_q : '0;
        end
    end

    assign lt     = (i_q < n_q);
    assign result = result_q;

endmodule

// File: rtl/hlsm_accum.sv
// Triangular sum sum(i, i=0..n-1) mod 2^WIDTH, launched by a one-cycle strobe on b.
// Optional macro HLSM_DONE_EN adds a done pulse aligned with the result cycle.
module hlsm_accum
    import hlsm_accum_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result
`ifdef HLSM_DONE_EN
    ,
    output logic             done
`endif
);

    state_e state_q, state_d;
    logic   load, clear, add, emit, lt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StWait;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        clear   = 1'b0;
        add     = 1'b0;
        emit    = 1'b0;
        unique case (state_q)
            StWait: begin
                if (b) begin
                    load    = 1'b1;
                    state_d = StInit;
                end
            end
            StInit: begin
                clear   = 1'b1;
                state_d = StCheck;
            end
            StCheck: begin
                if (lt) begin
                    state_d = StAdd;
                end else begin
                    emit    = 1'b1;
                    state_d = StWait;
                end
            end
            StAdd: begin
                add     = 1'b1;
                state_d = StCheck;
            end
            default: state_d = StWait;
        endcase
    end

    hlsm_accum_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .clear (clear),
        .add   (add),
        .emit  (emit),
        .n     (n),
        .lt    (lt),
        .result(result)
    );

`ifdef HLSM_DONE_EN
    logic done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= emit;
        end
    end

    assign done = done_q;
`endif

endmodule

// File: tb/tb_hlsm_accum.sv
// Self-checking bench for hlsm_accum: scoreboard of closed-form sums checked at fixed latency.
module tb_hlsm_accum;

    logic       clk;
    logic       rst;
    logic       b;
    logic [3:0] n;
    logic [3:0] result;
`ifdef HLSM_DONE_EN
    logic       done;
`endif

    int         n_cmp;
    int         n_err;
    logic [3:0] exp_q[$];

    hlsm_accum #(
        .WIDTH(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .b     (b),
        .n     (n),
        .result(result)
`ifdef HLSM_DONE_EN
        ,
        .done  (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " result"}, 32'(result), 32'd0);
`ifdef HLSM_DONE_EN
        chk({tag, " done"}, 32'(done), 32'd0);
`endif
    endtask

    // One operation; result must be 0 until edge E0+2n+2, then the scoreboard value.
    task automatic run_op(input logic [3:0] nv, input bit mut, input bit hold, input string tag);
        int         nn;
        int         lat;
        logic [3:0] e;
        nn  = int'(nv);
        lat = 2 * nn + 2;
        @(negedge clk);
        n = nv;
        b = 1'b1;
        @(posedge clk);
        exp_q.push_back(4'((nn * (nn - 1) / 2) % 16));
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (mut && k == 1) n = 4'd3;
            if (!hold) b = (k % 3 == 1);
            @(posedge clk);
            #1;
            if (k < lat) begin
                chk_idle({tag, " busy"});
            end else begin
                if (exp_q.size() == 0) begin
                    chk({tag, " scoreboard empty"}, 32'(result), 32'hffff);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, " result"}, 32'(result), 32'(e));
                end
`ifdef HLSM_DONE_EN
                chk({tag, " done"}, 32'(done), 32'd1);
`endif
            end
        end
        if (!hold) begin
            @(negedge clk);
            b = 1'b0;
            @(posedge clk);
            #1;
            chk_idle({tag, " after"});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        b     = 1'b0;
        n     = 4'd0;
        rst   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk_idle("idle");
        end

        run_op(4'd2, 1'b0, 1'b0, "n2");
        run_op(4'd5, 1'b0, 1'b0, "n5");
        run_op(4'd10, 1'b0, 1'b0, "n10");
        run_op(4'd0, 1'b0, 1'b0, "n0");
        run_op(4'd15, 1'b0, 1'b0, "n15");
        run_op(4'd5, 1'b1, 1'b0, "n5 mut");

        // b held high: back-to-back runs every 7 cycles.
        for (int r = 0; r < 3; r++) run_op(4'd2, 1'b0, 1'b1, "hold");
        @(negedge clk);
        b = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("hold end");

        // Abort an n=5 run with reset at E0+3.
        @(negedge clk);
        n = 4'd5;
        b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("abort");
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_idle("abort hold");
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("abort release");
        run_op(4'd5, 1'b0, 1'b0, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
